fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'haaaaa000, the PC loaded at reset.
REQ-002 SHALL provide parameter FETCH_WIDTH, default 2, the maximum instructions enqueued per cycle; legal values are 1, 2, 4.
REQ-003 SHALL provide parameter LINE_BYTES, default 32, the cache line size in bytes; legal values are 32, 64.
REQ-004 SHALL provide clk  input  1  the single clock.
REQ-005 SHALL provide rst  input  1  the reset; asynchronous, active-low.
REQ-006 SHALL provide ufp_addr  output  32  line-aligned I-cache request address.
REQ-007 SHALL provide ufp_rmask  output  4  read request; 4'hF while a request is pending, else 0.
REQ-008 SHALL provide ufp_rcache_line  input  LINE_BYTES*8  the returned line.
REQ-009 SHALL provide ufp_resp  input  1  one-cycle response strobe.
REQ-010 SHALL provide enq_o  output  1  enqueue strobe to the instruction queue.
REQ-011 SHALL provide enq_count_o  output  3  number of valid slots this cycle, 1..FETCH_WIDTH.
REQ-012 SHALL provide enq_instr_o  output  FETCH_WIDTH*32  instructions; slot 0 in the LSBs.
REQ-013 SHALL provide enq_pc_o  output  32  PC of slot 0.
REQ-014 SHALL provide enq_order_o  output  64  order of slot 0; slot k has order enq_order_o+k.
REQ-015 SHALL provide free_slots_i  input  6  free entries in the queue.
REQ-016 SHALL provide redirect_i  input  1  redirect request.
REQ-017 SHALL provide redirect_pc_i  input  32  redirect target.
REQ-018 SHALL provide flush_i  input  1  line-buffer invalidate (fence.i).

Function
REQ-019 SHALL hold a one-entry line buffer: data, line tag pc[31:log2(LINE_BYTES)], and a valid bit.
REQ-020 SHALL treat a cycle as a hit when the buffer is valid and its tag equals the current pc tag.
REQ-021 On a hit, SHALL compute n = min(FETCH_WIDTH, words remaining in the line from pc[log2(LINE_BYTES)-1:2]); enqueue never crosses a line.
REQ-022 On a hit with free_slots_i >= n, SHALL assert enq_o combinationally in that cycle with count n, then advance pc by 4n and order by n at the next edge.
REQ-023 On a hit with free_slots_i < n, SHALL hold enq_o low and leave pc and order unchanged.
REQ-024 SHALL implement an FSM with states IDLE, REQ and DISCARD.
REQ-025 IDLE: on a miss with no redirect or flush, SHALL move to REQ and drive ufp_addr = pc with low bits cleared and ufp_rmask = 4'hF from the next cycle.
REQ-026 REQ: SHALL hold ufp_addr and ufp_rmask stable until ufp_resp.
REQ-027 REQ: on ufp_resp, SHALL write the line and the request tag into the buffer, set valid, drop ufp_rmask in the following cycle, and return to IDLE.
REQ-028 SHALL allow at most one outstanding request and SHALL NOT enqueue from the response cycle; the earliest enqueue is the cycle after the fill.
REQ-029 SHALL give redirect_i priority over enqueue: it suppresses enq_o that cycle, sets pc <= {redirect_pc_i[31:2], 2'b00} and keeps the order count.
REQ-030 SHALL preserve buffer contents on a redirect; a redirect in REQ stays in REQ and fills from the response as normal.
REQ-031 flush_i SHALL clear buffer valid and suppress enq_o that cycle.
REQ-032 flush_i in REQ SHALL move to DISCARD, which drops the response without filling, then returns to IDLE.
REQ-033 SHALL apply flush then redirect when flush_i and redirect_i arrive together.
REQ-034 SHALL allow redirect and flush to arrive in the same cycle as ufp_resp; flush wins and no fill occurs.
REQ-035 SHALL leave enq_count_o and enq_instr_o don't-care when enq_o is low.
REQ-036 SHALL let pc wrap modulo 2^32.

Reset
REQ-037 While rst is low, SHALL hold pc = RESET_PC, order = 0, state IDLE, buffer valid = 0, ufp_rmask = 0, ufp_addr = 0 and enq_o = 0.
REQ-038 SHALL take effect asynchronously at rst assertion, including mid-request; a response arriving after reset is ignored unless a new request is outstanding.

Verification
REQ-039 Cold start, FETCH_WIDTH=2, free=16 -> request to 0xaaaaa000; resp at cycle t; enq_o at t+1 with count 2, pc 0xaaaaa000, order 0; four such enqueues cover the line.
REQ-040 Partial line: redirect to 0xaaaaa01c after fill -> single enqueue with count 1, then a new request to 0xaaaaa020.
REQ-041 Backpressure: free_slots_i=1 with n=2 -> no enq_o and pc held; free_slots_i=2 -> enqueue resumes.
REQ-042 flush_i during REQ -> DISCARD; the response is dropped (valid stays 0); a fresh request to the same line follows.
REQ-043 redirect_i and ufp_resp in the same cycle -> line is filled; pc equals the redirect target with low bits cleared; no enq_o that cycle.
REQ-044 rst low mid-REQ -> ufp_rmask goes to 0 immediately; pc is RESET_PC after release.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Instruction fetch stage with a one-line buffer feeding the instruction queue
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'haaaaa000,
    parameter int          FETCH_WIDTH = 2,
    parameter int          LINE_BYTES  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [31:0]               ufp_addr,
    output logic [3:0]                ufp_rmask,
    input  logic [LINE_BYTES*8-1:0]   ufp_rcache_line,
    input  logic                      ufp_resp,
    output logic                      enq_o,
    output logic [2:0]                enq_count_o,
    output logic [FETCH_WIDTH*32-1:0] enq_instr_o,
    output logic [31:0]               enq_pc_o,
    output logic [63:0]               enq_order_o,
    input  logic [5:0]                free_slots_i,
    input  logic                      redirect_i,
    input  logic [31:0]               redirect_pc_i,
    input  logic                      flush_i
);

    localparam int OFF        = $clog2(LINE_BYTES);
    localparam int LINE_WORDS = LINE_BYTES / 4;
    localparam int TAG_W      = 32 - OFF;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [31:0]             r_pc;
    logic [63:0]             r_order;
    logic [LINE_BYTES*8-1:0] r_buf_data;
    logic [TAG_W-1:0]        r_buf_tag;
    logic                    r_buf_valid;
    logic [31:0]             r_req_addr;

    logic                    w_hit;
    logic                    w_can_enq;
    logic                    w_issue;
    logic                    w_fill;
    logic [OFF-3:0]          w_word_idx;
    logic [4:0]              w_remain;
    logic [4:0]              w_n;

    assign w_hit      = r_buf_valid && (r_buf_tag == r_pc[31:OFF]);
    assign w_word_idx = r_pc[OFF-1:2];

    // Slots available before the end of the line; enqueue never spans two lines.
    always_comb begin
        w_remain = 5'(LINE_WORDS) - 5'(w_word_idx);
        w_n      = (w_remain < 5'(FETCH_WIDTH)) ? w_remain : 5'(FETCH_WIDTH);
    end

    // Only IDLE enqueues, so the response cycle itself can never enqueue.
    assign w_can_enq = (r_state == IDLE) && w_hit && !redirect_i && !flush_i
                       && (free_slots_i >= 6'(w_n));

    assign enq_o       = w_can_enq;
    assign enq_count_o = w_n[2:0];
    assign enq_pc_o    = r_pc;
    assign enq_order_o = r_order;
    assign ufp_addr    = r_req_addr;
    assign ufp_rmask   = (r_state != IDLE) ? 4'hF : 4'h0;

    always_comb begin
        enq_instr_o = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            enq_instr_o[k*32 +: 32] = r_buf_data[((int'(w_word_idx) + k) % LINE_WORDS)*32 +: 32];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_fill      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_hit && !redirect_i && !flush_i) begin
                    w_state_nxt = REQ;
                    w_issue     = 1'b1;
                end
            end
            REQ: begin
                // A flush coinciding with the response drops it and nothing is left to discard.
                if (flush_i) begin
                    w_state_nxt = ufp_resp ? IDLE : DISCARD;
                end else if (ufp_resp) begin
                    w_fill      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            DISCARD: begin
                if (ufp_resp) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_order     <= '0;
            r_buf_data  <= '0;
            r_buf_tag   <= '0;
            r_buf_valid <= 1'b0;
            r_req_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_req_addr <= {r_pc[31:OFF], {OFF{1'b0}}};
            end
            if (flush_i) begin
                r_buf_valid <= 1'b0;
            end else if (w_fill) begin
                r_buf_valid <= 1'b1;
                r_buf_data  <= ufp_rcache_line;
                r_buf_tag   <= r_req_addr[31:OFF];
            end
            if (redirect_i) begin
                r_pc <= redirect_pc_i & 32'hFFFF_FFFC;
            end else if (w_can_enq) begin
                r_pc    <= r_pc + 32'({w_n, 2'b00});
                r_order <= r_order + 64'(w_n);
            end
        end
    end

endmodule
